hd44780_bus_driver: RTL and testbench

- Physical-interface stage directly downstream of the HD44780 byte formatter in the clock display path.
- Takes one formatted byte plus a register-select flag per request and drives the 8-bit HD44780 parallel bus (RS, RW, E, DB7..DB0) with the setup, enable-pulse, hold and execution timing the controller requires.
- Also enforces the power-on delay after reset.
- Signals busy/done back to the upstream sequencer so it can pace clear, function-set and character writes.

---
 rtl/hd44780_bus_driver.sv | 140 ++++++++++++++
 tb/tb_hd44780_bus_driver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_bus_driver.sv
// HD44780 8-bit parallel bus driver: turns one {rs, byte} request into a timed
// E strobe with setup, hold and execution waits, after an initial power-on delay.
module hd44780_bus_driver #(
   parameter int POWERON_CYC = 4000000,
   parameter int SETUP_CYC   = 4,
   parameter int EHIGH_CYC   = 25,
   parameter int HOLD_CYC    = 2,
   parameter int EXEC_CYC    = 4000,
   parameter int CLEAR_CYC   = 160000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_rs,
   input  logic [7:0] i_d,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_e,
   output logic [7:0] o_lcd_db
);

   localparam int CW = 22;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_IDLE,
      ST_SETUP,
      ST_EHIGH,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_long;
   logic          r_e;
   logic          r_rs;
   logic          r_busy;
   logic          r_done;
   logic [7:0]    r_db;

   logic          w_long;
   logic [CW-1:0] w_waitLast;

   // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution wait
   assign w_long     = ~i_rs & (i_d[7:2] == 6'b000000);
   assign w_waitLast = r_long ? CW'(CLEAR_CYC - 1) : CW'(EXEC_CYC - 1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_POWERUP;
         r_cnt   <= '0;
         r_long  <= 1'b0;
         r_e     <= 1'b0;
         r_rs    <= 1'b0;
         r_db    <= 8'h00;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_POWERUP: begin
               if (r_cnt == CW'(POWERON_CYC - 1)) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               r_done <= 1'b0;
               r_e    <= 1'b0;
               if (i_start) begin
                  r_rs    <= i_rs;
                  r_db    <= i_d;
                  r_long  <= w_long;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_cnt == CW'(SETUP_CYC - 1)) begin
                  r_cnt   <= '0;
                  r_e     <= 1'b1;
                  r_state <= ST_EHIGH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_EHIGH: begin
               if (r_cnt == CW'(EHIGH_CYC - 1)) begin
                  r_cnt   <= '0;
                  r_e     <= 1'b0;
                  r_state <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (r_cnt == CW'(HOLD_CYC - 1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_WAIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WAIT: begin
               // busy drops and done pulses together so the sequencer can issue
               // the next request on this very cycle
               if (r_cnt == w_waitLast) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_e     <= 1'b0;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
               r_state <= ST_POWERUP;
            end
         endcase
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_lcd_rs = r_rs;
   assign o_lcd_rw = 1'b0;
   assign o_lcd_e  = r_e;
   assign o_lcd_db = r_db;

endmodule

// File: tb/tb_hd44780_bus_driver.sv
// Self-checking bench for hd44780_bus_driver with shortened timing parameters.
module tb_hd44780_bus_driver;

   localparam int POWERON = 20;
   localparam int SETUP   = 2;
   localparam int EHIGH   = 5;
   localparam int HOLD    = 1;
   localparam int EXEC    = 10;
   localparam int CLEAR   = 50;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       start = 1'b0;
   logic       rs = 1'b0;
   logic [7:0] d = 8'h00;
   logic       busy, done, lcdRs, lcdRw, lcdE;
   logic [7:0] lcdDb;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hd44780_bus_driver #(
      .POWERON_CYC(POWERON),
      .SETUP_CYC(SETUP),
      .EHIGH_CYC(EHIGH),
      .HOLD_CYC(HOLD),
      .EXEC_CYC(EXEC),
      .CLEAR_CYC(CLEAR)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_start(start),
      .i_rs(rs),
      .i_d(d),
      .o_busy(busy),
      .o_done(done),
      .o_lcd_rs(lcdRs),
      .o_lcd_rw(lcdRw),
      .o_lcd_e(lcdE),
      .o_lcd_db(lcdDb)
   );

   typedef struct {
      logic       vRs;
      logic [7:0] vD;
      int         expDone;
      bit         inject;
   } vec_t;

   vec_t vecs[8];

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Expects rstN low on entry; checks reset values, releases, then times power-up
   task automatic powerUpCheck();
      int busyFall = -1;
      int eSeen = 0;
      int doneSeen = 0;
      @(negedge clk);
      checkOutput("reset e", int'(lcdE), 0);
      checkOutput("reset rs", int'(lcdRs), 0);
      checkOutput("reset rw", int'(lcdRw), 0);
      checkOutput("reset db", int'(lcdDb), 0);
      checkOutput("reset busy", int'(busy), 1);
      checkOutput("reset done", int'(done), 0);
      rstN = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            start = 1'b1;
            rs = 1'b1;
            d = 8'h50;
         end
         if (k == 6) start = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (busy == 1'b0 && busyFall < 0) busyFall = k;
         if (lcdE) eSeen++;
         if (done) doneSeen++;
      end
      checkOutput("powerup busy fall cycle", busyFall, POWERON);
      checkOutput("powerup e activity", eSeen, 0);
      checkOutput("powerup done pulses", doneSeen, 0);
      checkOutput("powerup db untouched", int'(lcdDb), 0);
      checkOutput("powerup rs untouched", int'(lcdRs), 0);
   endtask

   // One complete write from IDLE, optionally with an ignored request mid-write
   task automatic applyStimulus(input logic vRs, input logic [7:0] vD,
                                input int expDone, input bit inject);
      int eRise = -1;
      int eWidth = 0;
      int ePulses = 0;
      int doneK = -1;
      int doneCnt = 0;
      int busyCnt = 0;
      int dbBad = 0;
      int busyAtDone = -1;
      logic prevE;
      @(negedge clk);
      checkOutput("pre-write idle busy", int'(busy), 0);
      start = 1'b1;
      rs = vRs;
      d = vD;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("accept busy", int'(busy), 1);
      checkOutput("accept rs", int'(lcdRs), int'(vRs));
      checkOutput("accept db", int'(lcdDb), int'(vD));
      busyCnt = int'(busy);
      prevE = lcdE;
      for (int k = 1; k <= 300; k++) begin
         if (inject && k == 5) begin
            start = 1'b1;
            rs = ~vRs;
            d = 8'h50;
         end
         if (inject && k == 6) start = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (lcdE && !prevE) begin
            ePulses++;
            if (eRise < 0) eRise = k;
         end
         if (lcdE) eWidth++;
         prevE = lcdE;
         if (busy) busyCnt++;
         if (done) begin
            doneCnt++;
            if (doneK < 0) begin
               doneK = k;
               busyAtDone = int'(busy);
            end
         end
         if (lcdDb !== vD || lcdRs !== vRs || lcdRw !== 1'b0) dbBad++;
         if (doneK >= 0 && k >= doneK + 4) break;
      end
      checkOutput($sformatf("d=%0h e rise cycle", vD), eRise, SETUP);
      checkOutput($sformatf("d=%0h e width", vD), eWidth, EHIGH);
      checkOutput($sformatf("d=%0h e pulses", vD), ePulses, 1);
      checkOutput($sformatf("d=%0h done cycle", vD), doneK, expDone);
      checkOutput($sformatf("d=%0h done pulses", vD), doneCnt, 1);
      checkOutput($sformatf("d=%0h busy at done", vD), busyAtDone, 0);
      checkOutput($sformatf("d=%0h busy cycles", vD), busyCnt, expDone);
      checkOutput($sformatf("d=%0h bus stable", vD), dbBad, 0);
   endtask

   task automatic backToBack();
      logic [7:0] bytes[4];
      int expDone[4];
      int acc = 0;
      int idx = 0;
      int pulseCount = 0;
      bit justAccepted = 1'b0;
      logic prevE;
      bytes[0] = 8'h34;
      bytes[1] = 8'h0C;
      bytes[2] = 8'h01;
      bytes[3] = 8'h06;
      for (int i = 0; i < 4; i++) begin
         expDone[i] = acc + SETUP + EHIGH + HOLD + ((bytes[i] <= 8'h03) ? CLEAR : EXEC);
         acc = expDone[i] + 1;
      end
      @(negedge clk);
      start = 1'b1;
      rs = 1'b0;
      d = bytes[0];
      @(posedge clk);
      @(negedge clk);
      prevE = lcdE;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (justAccepted) begin
            checkOutput("b2b reaccept busy", int'(busy), 1);
            checkOutput("b2b reaccept db", int'(lcdDb), int'(bytes[idx]));
            justAccepted = 1'b0;
         end
         if (lcdE && !prevE) begin
            if (pulseCount < 4) checkOutput("b2b pulse db", int'(lcdDb), int'(bytes[pulseCount]));
            pulseCount++;
         end
         prevE = lcdE;
         if (done) begin
            if (idx < 4) checkOutput($sformatf("b2b done %0d cycle", idx), k, expDone[idx]);
            checkOutput("b2b busy at done", int'(busy), 0);
            idx++;
            if (idx < 4) begin
               d = bytes[idx];
               justAccepted = 1'b1;
            end else begin
               start = 1'b0;
            end
         end
         if (idx >= 4 && k >= expDone[3] + 4) break;
      end
      start = 1'b0;
      checkOutput("b2b total pulses", pulseCount, 4);
      checkOutput("b2b total dones", idx, 4);
   endtask

   task automatic resetMidPulse();
      int found = 0;
      @(negedge clk);
      start = 1'b1;
      rs = 1'b1;
      d = 8'h77;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (lcdE) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("midpulse e reached", found, 1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async reset e", int'(lcdE), 0);
      checkOutput("async reset db", int'(lcdDb), 0);
      checkOutput("async reset busy", int'(busy), 1);
      checkOutput("async reset rs", int'(lcdRs), 0);
      powerUpCheck();
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h41, 18, 1'b0};
      vecs[1] = '{1'b0, 8'h01, 58, 1'b0};
      vecs[2] = '{1'b0, 8'h0C, 18, 1'b0};
      vecs[3] = '{1'b1, 8'h01, 18, 1'b0};
      vecs[4] = '{1'b0, 8'h02, 58, 1'b0};
      vecs[5] = '{1'b0, 8'h03, 58, 1'b0};
      vecs[6] = '{1'b0, 8'h04, 18, 1'b0};
      vecs[7] = '{1'b1, 8'h41, 18, 1'b1};

      rstN = 1'b0;
      #23;
      powerUpCheck();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].vRs, vecs[i].vD, vecs[i].expDone, vecs[i].inject);
      end
      backToBack();
      resetMidPulse();
      applyStimulus(1'b1, 8'h5A, 18, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
